quad_encoder_gen: RTL and testbench
===================================

Name: quad_encoder_gen

Overview:
- Quadrature encoder generator. Emits a commanded number of A/B quadrature edges at a programmable edge rate.
- Used to emulate motor encoders for closed-loop bring-up, and as a stimulus source for quad_counter on the HPS/FPGA fabric.
- Direction and edge counting match quad_counter exactly: one emitted edge equals one count in the decoder.
- A start/busy/done handshake lets the HPS issue relative moves.

Parameters:
- COUNT_W, 32, width of the step command, remaining counter and position output.
- DIV_W, 16, width of the edge-period value.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high, sampled on posedge clk.
- start  in  1  command strobe; accepted only when busy=0.
- steps  in  COUNT_W  signed two's-complement edge count for the move; sampled when start is accepted.
- period  in  DIV_W  clk cycles between successive edges; sampled when start is accepted; 0 is treated as 1.
- abort  in  1  terminates an active move.
- quadA  out  1  encoder channel A, registered.
- quadB  out  1  encoder channel B, registered.
- busy  out  1  high while a move is in progress.
- done  out  1  one-cycle pulse on normal move completion.
- position  out  COUNT_W  signed running edge count since reset.

Behaviour:
- Reset values: quadA=0, quadB=0, phase=0, position=0, busy=0, done=0. Internal timer and remaining counter are cleared.
- Reset has priority over start and abort. Reset mid-move aborts immediately: no done pulse, outputs return to 00.
- Phase encoding (A,B): 0=00, 1=10, 2=11, 3=01.
- Positive step: phase+1 mod 4 (A leads B). position increments by 1.
- Negative step: phase-1 mod 4. position decrements by 1.
- Phase persists between moves. Only reset returns it to 0.
- States: IDLE, RUN.
- IDLE, start=1, steps!=0 (accepted at edge t0):
  - Latch direction = sign(steps) and remaining = |steps|.
  - |steps| is held unsigned in COUNT_W bits, so -2^(COUNT_W-1) gives 2^(COUNT_W-1) edges.
  - Latch P = max(period,1). Load timer. busy=1 from edge t0. Go to RUN.
- IDLE, start=1, steps=0: no edges, busy stays 0, done=1 for the single cycle after edge t0+1.
- RUN timing:
  - Edge k (k=1..N, N=|steps|) updates quadA/quadB/position at edge t0+k*P.
  - Exactly one channel toggles per edge.
  - Timer reloads after each edge.
- Completion: at edge t0+N*P, the last edge is emitted, busy=0 and done=1 (one cycle), state returns to IDLE.
- Back-to-back moves: a new start is accepted one cycle after done. The first edge of the new move occurs P cycles after acceptance.
- start while busy=1: ignored, and latched parameters do not change.
- Changes to steps or period during RUN have no effect.
- abort in RUN: at the next edge, go to IDLE, busy=0, no done pulse. quadA/quadB/position hold their last values, and no partial edge is emitted.
- abort in IDLE: no effect.
- abort and start in the same cycle while IDLE: start is accepted and abort is ignored.
- Timer expiry and abort in the same cycle: abort wins and the edge is not emitted.
- position wraps modulo 2^COUNT_W with no saturation.
- quadA and quadB are glitch-free register outputs. Minimum edge spacing is 1 clk.

Test Plan:
- Reset, then start with steps=+4, period=3 -> (A,B) sequence 10,11,01,00 at edges t0+3/6/9/12; position 1,2,3,4; done at t0+12; quad_counter count=+4 after settling.
- steps=-6, period=1 from phase 0 -> (A,B) 01,11,10,00,01,11 on consecutive cycles; position=-6; final phase=2; quad_counter count=-6.
- steps=+100, period=5, abort asserted at t0+52 -> exactly 10 edges; position=10; busy=0 at t0+53; done never pulses.
- steps=0, period=7 -> no edge, busy stays 0, single done pulse.
- Second start pulsed during a busy move (steps=+8, period=2; second command steps=-3) -> ignored; position=+8; then steps=-3 issued after done gives position=+5.
- period=0, steps=+2 -> edges on consecutive cycles, identical to period=1.
- Reset asserted mid-move after 3 edges -> next cycle A=B=0, position=0, busy=0, no done.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B edge generator: emits a signed number of edges
// at a programmable edge period, with start/busy/done handshake.
module quad_encoder_gen #(
    parameter int COUNT_W = 32,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] steps,
    input  logic [DIV_W-1:0]   period,
    input  logic               abort,
    output logic               quadA,
    output logic               quadB,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] position
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [DIV_W-1:0]   DIV_ONE = DIV_W'(1);

    state_t             state;
    logic [DIV_W-1:0]   timer;
    logic [DIV_W-1:0]   reload;
    logic [COUNT_W-1:0] remaining;
    logic               dir_neg;
    logic               zero_pend;

    logic [COUNT_W-1:0] mag;
    logic [DIV_W-1:0]   per_m1;

    // Magnitude is unsigned, so the most negative command yields 2^(W-1) edges.
    assign mag    = steps[COUNT_W-1] ? (~steps + CNT_ONE) : steps;
    assign per_m1 = (period == '0) ? '0 : (period - DIV_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            reload    <= '0;
            remaining <= '0;
            dir_neg   <= 1'b0;
            zero_pend <= 1'b0;
            quadA     <= 1'b0;
            quadB     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            position  <= '0;
        end else begin
            done      <= zero_pend;
            zero_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (steps != '0) begin
                            dir_neg   <= steps[COUNT_W-1];
                            remaining <= mag;
                            reload    <= per_m1;
                            timer     <= per_m1;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            zero_pend <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timer == '0) begin
                        // Gray step: forward (A,B)->(~B,A), reverse (A,B)->(B,~A).
                        if (dir_neg) begin
                            quadA    <= quadB;
                            quadB    <= ~quadA;
                            position <= position - CNT_ONE;
                        end else begin
                            quadA    <= ~quadB;
                            quadB    <= quadA;
                            position <= position + CNT_ONE;
                        end
                        timer     <= reload;
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - DIV_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: vector table plus
// hand sequences, with an independent quadrature decoder.
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] steps = '0;
    logic [15:0] period = '0;
    logic        abort = 1'b0;
    logic        quadA, quadB, busy, done;
    logic [31:0] position;

    quad_encoder_gen #(.COUNT_W(32), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .steps(steps),
        .period(period), .abort(abort), .quadA(quadA), .quadB(quadB),
        .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;
    int dec = 0;
    int illegal = 0;
    logic [1:0] prev_ab = 2'b00;
    logic edge_now = 1'b0;

    typedef struct {
        logic       rst_first;
        int         steps;
        int         period;
        logic       abort_start;
        int         abort_at;
        int         window;
        int         exp_edges;
        int         exp_first;
        int         exp_pos;
        logic [1:0] exp_ab;
        int         exp_done;
        int         exp_idle;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        nchecks++;
        if (got != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] cur;
        @(posedge clk);
        #1;
        edge_now = 1'b0;
        cur = {quadA, quadB};
        if (reset) begin
            dec = 0;
        end else if (cur != prev_ab) begin
            edge_now = 1'b1;
            if (cur == {~prev_ab[0], prev_ab[1]}) dec++;
            else if (cur == {prev_ab[0], ~prev_ab[1]}) dec--;
            else illegal++;
        end
        prev_ab = cur;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int edges, first, done_off, done_cnt, idle_off;
        v = vecs[idx];
        if (v.rst_first) do_reset();
        steps  = v.steps;
        period = v.period[15:0];
        start  = 1'b1;
        abort  = v.abort_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        edges = 0; first = -1; done_off = -1; done_cnt = 0; idle_off = -1;
        for (int off = 0; off <= v.window; off++) begin
            if (off > 0) tick();
            if (edge_now) begin
                edges++;
                if (first < 0) first = off;
            end
            if (done) begin
                done_cnt++;
                if (done_off < 0) done_off = off;
            end
            if (!busy && idle_off < 0) idle_off = off;
            abort = (off == v.abort_at);
        end
        abort = 1'b0;
        check($sformatf("v%0d edges", idx), edges, v.exp_edges);
        check($sformatf("v%0d first_edge", idx), first, v.exp_first);
        check($sformatf("v%0d position", idx), $signed(position), v.exp_pos);
        check($sformatf("v%0d ab", idx), {quadA, quadB}, v.exp_ab);
        check($sformatf("v%0d done_at", idx), done_off, v.exp_done);
        check($sformatf("v%0d done_pulses", idx), done_cnt,
              (v.exp_done >= 0) ? 1 : 0);
        check($sformatf("v%0d busy_low_at", idx), idle_off, v.exp_idle);
        check($sformatf("v%0d decoder", idx), dec, $signed(position));
    endtask

    initial begin
        int edges, first, done_off, done_cnt, busy_cnt;
        vecs[0] = '{1'b1,   4, 3, 1'b0, -1, 20,  4,  3,  4, 2'b00, 12, 12};
        vecs[1] = '{1'b1,  -6, 1, 1'b0, -1, 20,  6,  1, -6, 2'b11,  6,  6};
        vecs[2] = '{1'b0, 100, 5, 1'b0, 52, 70, 10,  5,  4, 2'b00, -1, 53};
        vecs[3] = '{1'b0,   0, 7, 1'b0, -1, 20,  0, -1,  4, 2'b00,  1,  0};
        vecs[4] = '{1'b0,   2, 0, 1'b0, -1, 20,  2,  1,  6, 2'b11,  2,  2};
        vecs[5] = '{1'b0,  -1, 1, 1'b0, -1, 20,  1,  1,  5, 2'b10,  1,  1};
        vecs[6] = '{1'b0,   5, 4, 1'b0,  7, 20,  1,  4,  6, 2'b11, -1,  8};
        vecs[7] = '{1'b0,   3, 2, 1'b1, -1, 20,  3,  2,  9, 2'b10,  6,  6};

        do_reset();
        check("reset ab", {quadA, quadB}, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset position", position, 0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Start while busy is ignored; then back-to-back move after done.
        do_reset();
        steps = 8; period = 2; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0; done_off = -1;
        for (int off = 1; off <= 40 && done_off < 0; off++) begin
            tick();
            if (edge_now) edges++;
            if (done) done_off = off;
            if (off == 5) begin
                start = 1'b1; steps = -3; period = 1;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_start edges", edges, 8);
        check("busy_start done_at", done_off, 16);
        check("busy_start position", $signed(position), 8);
        steps = -3; period = 2; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b accepted busy", busy, 1);
        check("b2b done cleared", done, 0);
        edges = 0; first = -1; done_off = -1;
        for (int off = 1; off <= 20 && done_off < 0; off++) begin
            tick();
            if (edge_now) begin
                edges++;
                if (first < 0) first = off;
            end
            if (done) done_off = off;
        end
        check("b2b first_edge", first, 2);
        check("b2b done_at", done_off, 6);
        check("b2b edges", edges, 3);
        check("b2b position", $signed(position), 5);

        // Reset in the middle of a move.
        do_reset();
        steps = 10; period = 1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("midrst pre position", position, 3);
        check("midrst pre ab", {quadA, quadB}, 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst ab", {quadA, quadB}, 0);
        check("midrst position", position, 0);
        check("midrst busy", busy, 0);
        done_cnt = 0; busy_cnt = 0; edges = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (edge_now) edges++;
        end
        check("midrst done_pulses", done_cnt, 0);
        check("midrst busy_after", busy_cnt, 0);
        check("midrst edges_after", edges, 0);

        check("illegal transitions", illegal, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
